// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, the common command bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_SETUP,
        ST_REQ,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_OK,
        ST_FAIL
    } state_t;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    // Odd parity: the parity bit makes the total count of ones across 9 bits odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// The requester pulses send with cmd_byte; the transmitter reports busy/done/error.
interface ps2_host_tx_if;
    logic       send;
    logic [7:0] cmd_byte;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output send, output cmd_byte, input busy, input done, input error);
    modport slave  (input send, input cmd_byte, output busy, output done, output error);
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for an asynchronous PS/2 line with a registered falling-edge flag.
// The fall flag is high for one cycle, three cycles after the pin drops.
module ps2_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic line,
    output logic line_sync,
    output logic fall
);
    logic meta;
    logic prev;

    // Idle PS/2 lines sit high, so the chain resets to 1 to avoid a false edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            prev      <= 1'b1;
            fall      <= 1'b0;
        end else begin
            meta      <= line;
            line_sync <= meta;
            prev      <= line_sync;
            fall      <= prev & ~line_sync;
        end
    end
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send, then
// shifts one command byte out on device clock edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES        = 5000,
    parameter int START_TIMEOUT_CYCLES  = 750000,
    parameter int PACKET_TIMEOUT_CYCLES = 100000
) (
    input  logic          clock,
    input  logic          reset,
    ps2_host_tx_if.slave  bus,
    inout  wire           ps2_clock,
    inout  wire           ps2_data
);

    localparam int INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int START_W = (START_TIMEOUT_CYCLES > 1) ? $clog2(START_TIMEOUT_CYCLES) : 1;
    localparam int PKT_W   = (PACKET_TIMEOUT_CYCLES > 1) ? $clog2(PACKET_TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT_CYCLES - 1);
    localparam logic [PKT_W-1:0]   PKT_LAST   = PKT_W'(PACKET_TIMEOUT_CYCLES - 1);

    state_t             state, state_d;
    logic [7:0]         byte_q, byte_d;
    logic               oe_clk, oe_clk_d;
    logic               oe_dat, oe_dat_d;
    logic [3:0]         edge_cnt, edge_cnt_d;
    logic [3:0]         next_edge;
    logic [2:0]         bit_idx;
    logic [INH_W-1:0]   inh_cnt, inh_d;
    logic [START_W-1:0] start_cnt, start_d;
    logic [PKT_W-1:0]   pkt_cnt, pkt_d;

    logic clk_sync;
    logic clk_fall;
    logic dat_meta;
    logic dat_sync;

    // Open-drain: the block only ever pulls low or lets go.
    assign ps2_clock = oe_clk ? 1'b0 : 1'bz;
    assign ps2_data  = oe_dat ? 1'b0 : 1'bz;

    ps2_line_sync u_clk_sync (
        .clock     (clock),
        .reset     (reset),
        .line      (ps2_clock),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            dat_meta <= ps2_data;
            dat_sync <= dat_meta;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            byte_q    <= '0;
            oe_clk    <= 1'b0;
            oe_dat    <= 1'b0;
            edge_cnt  <= '0;
            inh_cnt   <= '0;
            start_cnt <= '0;
            pkt_cnt   <= '0;
        end else begin
            state     <= state_d;
            byte_q    <= byte_d;
            oe_clk    <= oe_clk_d;
            oe_dat    <= oe_dat_d;
            edge_cnt  <= edge_cnt_d;
            inh_cnt   <= inh_d;
            start_cnt <= start_d;
            pkt_cnt   <= pkt_d;
        end
    end

    always_comb begin
        state_d    = state;
        byte_d     = byte_q;
        oe_dat_d   = oe_dat;
        edge_cnt_d = edge_cnt;
        inh_d      = inh_cnt;
        start_d    = start_cnt;
        pkt_d      = pkt_cnt;
        next_edge  = edge_cnt + 4'd1;
        bit_idx    = 3'(next_edge - 4'd1);

        case (state)
            ST_IDLE: begin
                if (bus.send) begin
                    byte_d  = bus.cmd_byte;
                    inh_d   = '0;
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    oe_dat_d = 1'b1;
                    state_d  = ST_SETUP;
                end else begin
                    inh_d = inh_cnt + INH_W'(1);
                end
            end
            ST_SETUP: begin
                start_d = '0;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                if (clk_fall) begin
                    oe_dat_d   = ~byte_q[0];
                    edge_cnt_d = 4'd1;
                    pkt_d      = '0;
                    state_d    = ST_XFER;
                end else if (start_cnt == START_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    start_d = start_cnt + START_W'(1);
                end
            end
            ST_XFER: begin
                // A device edge wins over a timeout landing in the same cycle.
                if (clk_fall) begin
                    edge_cnt_d = next_edge;
                    if (pkt_cnt != PKT_LAST) pkt_d = pkt_cnt + PKT_W'(1);
                    if (next_edge <= 4'd8)       oe_dat_d = ~byte_q[bit_idx];
                    else if (next_edge == 4'd9)  oe_dat_d = ~odd_parity(byte_q);
                    else if (next_edge == 4'd10) oe_dat_d = 1'b0;
                    else                         state_d  = dat_sync ? ST_FAIL : ST_WAIT_IDLE;
                end else if (pkt_cnt == PKT_LAST) begin
                    state_d = ST_FAIL;
                end else begin
                    pkt_d = pkt_cnt + PKT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync)    state_d = ST_OK;
                else if (pkt_cnt == PKT_LAST) state_d = ST_FAIL;
                else                          pkt_d   = pkt_cnt + PKT_W'(1);
            end
            ST_OK:   state_d = ST_IDLE;
            ST_FAIL: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d inside {ST_IDLE, ST_INHIBIT, ST_WAIT_IDLE, ST_OK, ST_FAIL}) oe_dat_d = 1'b0;
        oe_clk_d = (state_d == ST_INHIBIT) || (state_d == ST_SETUP);
    end

    assign bus.busy  = (state != ST_IDLE);
    assign bus.done  = (state == ST_OK);
    assign bus.error = (state == ST_FAIL);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + randomized bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 50;
    localparam int STO = 600;
    localparam int PTO = 1500;

    logic clock = 1'b0;
    logic reset = 1'b1;
    wire  ps2_clock;
    wire  ps2_data;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    pullup (ps2_clock);
    pullup (ps2_data);
    assign ps2_clock = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_data  = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES        (INH),
        .START_TIMEOUT_CYCLES  (STO),
        .PACKET_TIMEOUT_CYCLES (PTO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .ps2_clock (ps2_clock),
        .ps2_data  (ps2_data)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int host_low = 0;
    int edge1_cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Activity monitor sampled just after the falling edge, when everything is settled.
    always begin
        @(negedge clock);
        #2;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
        if (bus.error === 1'b1) err_cnt <= err_cnt + 1;
        if (ps2_clock === 1'b0 && !dev_clk_low) host_low <= host_low + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
        return (ones % 2 == 0);
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clock);
        bus.cmd_byte = b;
        bus.send     = 1'b1;
        @(negedge clock);
        bus.send     = 1'b0;
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(tag, {31'd0, bus.busy}, 32'd0);
    endtask

    // Device side: wait for request-to-send, then generate n_edges clock pulses,
    // sampling host data while the clock is low and optionally ACKing on edge 11.
    task automatic dev_frame(input int n_edges, input bit ack, input int half,
                             output logic [7:0] bits, output logic par, output logic stp);
        int  n = 0;
        logic s;
        bits = '0; par = 1'b0; stp = 1'b0;
        while (!(ps2_clock === 1'b1 && ps2_data === 1'b0) && n < 20 * INH + 200) begin
            @(negedge clock);
            n++;
        end
        check("req_seen", {31'd0, (ps2_clock === 1'b1 && ps2_data === 1'b0)}, 32'd1);
        repeat (10) @(negedge clock);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (half) @(negedge clock);
            end
            dev_clk_low = 1'b1;
            if (e == 1) edge1_cyc = cyc;
            repeat (half) @(negedge clock);
            s = ps2_data;
            if (e <= 8)       bits[e-1] = s;
            else if (e == 9)  par = s;
            else if (e == 10) stp = s;
            dev_clk_low = 1'b0;
            repeat (half) @(negedge clock);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic run_good(input logic [7:0] b, input int half);
        int d0, e0, h0;
        logic [7:0] bits;
        logic par, stp;
        d0 = done_cnt; e0 = err_cnt; h0 = host_low;
        send_cmd(b);
        dev_frame(11, 1'b1, half, bits, par, stp);
        wait_not_busy(PTO, "good_busy_end");
        repeat (3) @(negedge clock);
        check("data_bits", {24'd0, bits}, {24'd0, b});
        check("parity", {31'd0, par}, {31'd0, model_parity(b)});
        check("stop", {31'd0, stp}, 32'd1);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("err_pulses", err_cnt - e0, 32'd0);
        check("clk_low_cycles", host_low - h0, INH + 1);
    endtask

    initial begin
        int d0, e0, h0, t0, n;
        logic [7:0] bits;
        logic par, stp;
        logic [7:0] rb;

        bus.send = 1'b0;
        bus.cmd_byte = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        check("rst_clk_rel", {31'd0, ps2_clock}, 32'd1);
        check("rst_dat_rel", {31'd0, ps2_data}, 32'd1);

        run_good(PS2_CMD_SET_LEDS, 40);
        run_good(8'h01, 30);
        run_good(PS2_CMD_RESET, 25);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom_range(0, 255));
            run_good(rb, int'($urandom_range(20, 40)));
        end

        // Device does not ACK on edge 11.
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(PS2_CMD_ENABLE);
        dev_frame(11, 1'b0, 30, bits, par, stp);
        wait_not_busy(PTO, "nak_busy_end");
        repeat (3) @(negedge clock);
        check("nak_err", err_cnt - e0, 32'd1);
        check("nak_done", done_cnt - d0, 32'd0);
        check("nak_clk_rel", {31'd0, ps2_clock}, 32'd1);
        check("nak_dat_rel", {31'd0, ps2_data}, 32'd1);

        // Device never clocks: start timeout.
        d0 = done_cnt;
        send_cmd(PS2_CMD_ENABLE);
        n = 0;
        while (!(ps2_clock === 1'b1 && ps2_data === 1'b0) && n < 20 * INH + 200) begin
            @(negedge clock);
            n++;
        end
        t0 = cyc;
        n = 0;
        while (bus.error !== 1'b1 && n < STO + 200) begin
            @(negedge clock);
            n++;
        end
        check("start_to_cycles", cyc - t0, STO);
        check("start_to_busy_last", {31'd0, bus.busy}, 32'd1);
        @(negedge clock);
        check("start_to_busy_drop", {31'd0, bus.busy}, 32'd0);
        check("start_to_no_done", done_cnt - d0, 32'd0);

        // Device stops after 5 edges; a send during busy must be ignored.
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(PS2_CMD_ENABLE);
        dev_frame(5, 1'b0, 30, bits, par, stp);
        check("stall_busy", {31'd0, bus.busy}, 32'd1);
        send_cmd(8'h55);
        n = 0;
        while (bus.error !== 1'b1 && n < PTO + 200) begin
            @(negedge clock);
            n++;
        end
        check("pkt_to_cycles", cyc - edge1_cyc, PTO + 4);
        repeat (3) @(negedge clock);
        h0 = host_low;
        check("pkt_to_err", err_cnt - e0, 32'd1);
        check("pkt_to_no_done", done_cnt - d0, 32'd0);
        repeat (300) @(negedge clock);
        check("no_extra_frame", host_low - h0, 32'd0);
        check("no_extra_busy", {31'd0, bus.busy}, 32'd0);

        // Reset in the middle of a frame, with data held low by the host.
        send_cmd(8'hF0);
        dev_frame(4, 1'b0, 30, bits, par, stp);
        check("mid_dat_low", {31'd0, ps2_data}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #2;
        check("arst_clk_rel", {31'd0, ps2_clock}, 32'd1);
        check("arst_dat_rel", {31'd0, ps2_data}, 32'd1);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt; h0 = host_low;
        repeat (100) @(negedge clock);
        check("arst_no_done", done_cnt - d0, 32'd0);
        check("arst_no_err", err_cnt - e0, 32'd0);
        check("arst_no_drive", host_low - h0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
